fetch_stage: RTL

//  Instruction-fetch (pre-IF + IF) stage of the pipelined LoongArch CPU; feeds the decode stage (ID).

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 48 ++++
 rtl/fetch_stage_inst_buf.sv | 34 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: reset PC, bus widths and bus field offsets.
// FS_TO_DS_BUS_WD depends on the FS_ADEF_EN build macro (65 bits with the adef flag, 64 without).
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h1c000000;
  localparam int unsigned BR_BUS_WD = 33;

`ifdef FS_ADEF_EN
  localparam int unsigned FS_TO_DS_BUS_WD = 65;
`else
  localparam int unsigned FS_TO_DS_BUS_WD = 64;
`endif

  // fs_to_ds_bus = {[adef,] fs_inst, fs_pc}
  localparam int unsigned FS_PC_LSB   = 0;
  localparam int unsigned FS_INST_LSB = 32;
  localparam int unsigned FS_ADEF_BIT = 64;

  // br_bus = {br_taken, br_target}
  localparam int unsigned BR_TAKEN_BIT = 32;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Interfaces of the fetch stage: IF->ID handshake/branch bus and the instruction SRAM port.
// master = fetch stage side, slave = ID stage / SRAM side.
interface fs_ds_if;
  import fetch_stage_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  modport master (
    input  ds_allowin,
    input  br_bus,
    output fs_to_ds_valid,
    output fs_to_ds_bus
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus
  );
endinterface

interface inst_sram_if;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata
  );
endinterface

// File: rtl/fetch_stage_inst_buf.sv
// Instruction holding register for the IF stage: keeps the SRAM word alive while ID stalls,
// since the SRAM read data is only guaranteed for the cycle after the read.
module fs_inst_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fs_allowin,
  input  logic        cancel,
  input  logic [31:0] rdata,
  output logic [31:0] inst_buf,
  output logic        buf_valid
);

  logic capture;

  // A cancel in the same cycle as the first stall cycle wins: nothing is buffered.
  assign capture = !fs_allowin && !cancel && !buf_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else begin
      if (fs_allowin || cancel) begin
        buf_valid <= 1'b0;
      end else if (capture) begin
        buf_valid <= 1'b1;
      end
      if (capture) begin
        inst_buf <= rdata;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Pre-IF + IF stage: nextpc generation, inst SRAM request, IF->ID handshake and branch redirect.
// Build macro FS_ADEF_EN adds the address-error (adef) flag on misaligned fetch PCs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         resetn,
  fs_ds_if.master      fs_ds,
  inst_sram_if.master  inst_sram
);
  import fetch_stage_pkg::*;

  br_bus_t     br;
  logic        rst_done;
  logic        to_fs_valid;
  logic        fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_go;
  logic        cancel;
  logic        br_pend;
  logic [31:0] br_pend_target;
  logic [31:0] fs_pc;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic [31:0] inst_buf;
  logic        buf_valid;
  logic        adef_next;
  logic        fs_adef;

  assign br = fs_ds.br_bus;

  assign to_fs_valid = rst_done;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid || (fs_ready_go && fs_ds.ds_allowin);
  assign fetch_go    = to_fs_valid && fs_allowin;
  assign cancel      = !fs_allowin && br.taken;
  assign seq_pc      = fs_pc + 32'd4;

  always_comb begin
    nextpc = seq_pc;
    if (br.taken) begin
      nextpc = br.target;
    end else if (br_pend) begin
      nextpc = br_pend_target;
    end
  end

`ifdef FS_ADEF_EN
  assign adef_next = pc_misaligned(nextpc);
  assign fs_adef   = pc_misaligned(fs_pc);
`else
  assign adef_next = 1'b0;
  assign fs_adef   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  // fs_pc only advances once fetching is enabled, so the first request after reset is RESET_PC.
  // The pending target is consumed by any fetch slot, including an adef slot with no SRAM read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      br_pend        <= 1'b0;
      br_pend_target <= '0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= to_fs_valid;
        if (to_fs_valid) begin
          fs_pc   <= nextpc;
          br_pend <= 1'b0;
        end
      end else if (br.taken) begin
        fs_valid       <= 1'b0;
        br_pend        <= 1'b1;
        br_pend_target <= br.target;
      end
    end
  end

  fs_inst_buf u_inst_buf (
    .clk        (clk),
    .resetn     (resetn),
    .fs_allowin (fs_allowin),
    .cancel     (cancel),
    .rdata      (inst_sram.inst_sram_rdata),
    .inst_buf   (inst_buf),
    .buf_valid  (buf_valid)
  );

  always_comb begin
    fs_inst = inst_sram.inst_sram_rdata;
    if (fs_adef) begin
      fs_inst = '0;
    end else if (buf_valid) begin
      fs_inst = inst_buf;
    end
  end

  assign fs_ds.fs_to_ds_valid = fs_valid && fs_ready_go && !br.taken;
`ifdef FS_ADEF_EN
  assign fs_ds.fs_to_ds_bus = {fs_adef, fs_inst, fs_pc};
`else
  assign fs_ds.fs_to_ds_bus = {fs_inst, fs_pc};
`endif

  assign inst_sram.inst_sram_en    = fetch_go && !adef_next;
  assign inst_sram.inst_sram_we    = 1'b0;
  assign inst_sram.inst_sram_addr  = nextpc;
  assign inst_sram.inst_sram_wdata = '0;

endmodule
